i2c_byte_master: RTL and testbench

//  Byte-level open-drain serial master (I2C-style) that drives a wired-AND SCL/SDA pair.

---
 rtl/i2c_byte_master.sv | 147 ++++++++++++++
 tb/tb_i2c_byte_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Byte-level open-drain serial master: optional START, 8 data bits MSB first, ack bit, optional STOP.
// Drives only pull-low enables; supports clock stretching and arbitration-loss detection.
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] tx_data,
  output logic       rsp_valid,
  output logic [7:0] rx_data,
  output logic       rsp_nack,
  output logic       rsp_arb,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [3:0]    bitcnt;
  logic          stop_l, read_l, ack_l;
  logic          scl_hold, nack_l, arb_l;
  logic [7:0]    shreg;
  logic          accept, active, freeze, qend, phase_end, bit_val, arb_hit;

  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state == START) || (state == BIT) || (state == STOP);
  assign freeze    = active && !scl_oe && !scl_in;
  assign qend      = !freeze && (qcnt == QMAX);
  assign phase_end = qend && (quarter == 2'd3);
  // Arbitration is judged only where we let SDA float on a write data bit or a bus condition
  assign arb_hit   = phase_end && !sda_oe && !sda_in &&
                     ((state == BIT && !read_l && bitcnt != 4'd8) ||
                      state == START || state == STOP);

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE) || rsp_valid;
    if (bitcnt == 4'd8) bit_val = read_l ? ack_l : 1'b1;
    else                bit_val = read_l ? 1'b1 : shreg[7];
    scl_oe = scl_hold;
    sda_oe = 1'b0;
    case (state)
      START: begin
        scl_oe = (quarter == 2'd0) ? scl_hold : (quarter == 2'd3);
        sda_oe = quarter[1];
      end
      BIT: begin
        scl_oe = ~quarter[1];
        sda_oe = ~bit_val;
      end
      STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = ~quarter[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = cmd_start ? START : BIT;
      START: if (arb_hit) state_nxt = DONE;
             else if (phase_end) state_nxt = BIT;
      BIT:   if (arb_hit) state_nxt = DONE;
             else if (phase_end && bitcnt == 4'd8) state_nxt = stop_l ? STOP : DONE;
      STOP:  if (phase_end) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      qcnt      <= '0;
      quarter   <= 2'd0;
      bitcnt    <= 4'd0;
      stop_l    <= 1'b0;
      read_l    <= 1'b0;
      ack_l     <= 1'b0;
      scl_hold  <= 1'b0;
      nack_l    <= 1'b0;
      arb_l     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
      rsp_arb   <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      rsp_valid <= (state == DONE);
      if (accept) begin
        qcnt    <= '0;
        quarter <= 2'd0;
        bitcnt  <= 4'd0;
        stop_l  <= cmd_stop;
        read_l  <= cmd_read;
        ack_l   <= cmd_ack;
        nack_l  <= 1'b0;
        arb_l   <= 1'b0;
      end else if (active) begin
        if (!freeze) qcnt <= (qcnt == QMAX) ? '0 : qcnt + 1'b1;
        if (qend) quarter <= quarter + 2'd1;
        if (phase_end && state == BIT) begin
          bitcnt <= bitcnt + 4'd1;
          // SCL stays held low after a byte that ends without STOP
          if (bitcnt == 4'd8) begin
            nack_l   <= !read_l && sda_in;
            scl_hold <= !stop_l;
          end
        end
        if (arb_hit) begin
          arb_l    <= 1'b1;
          scl_hold <= 1'b0;
        end
      end
      if (state == DONE) begin
        rsp_nack <= nack_l;
        rsp_arb  <= arb_l;
        if (read_l && bitcnt == 4'd9) rx_data <= shreg;
      end
    end
  end

  // Shared shifter: transmit byte shifts out MSB first while received bits shift in
  always_ff @(posedge clk) begin
    if (accept) shreg <= tx_data;
    else if (state == BIT && phase_end && bitcnt != 4'd8) shreg <= {shreg[6:0], sda_in};
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: pulled-up bus with an edge-counting slave, vector table,
// randomized commands against a reference model, and stretch/arbitration/reset sequences.
module tb_i2c_byte_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read, cmd_ack;
  logic [7:0] tx_data, rx_data;
  logic       rsp_valid, rsp_nack, rsp_arb, busy;
  logic       scl_oe, sda_oe, scl_in, sda_in;
  logic       slv_scl_low = 1'b0, slv_sda_low, force_sda_low = 1'b0;

  int tests = 0;
  int fails = 0;

  i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_read(cmd_read), .cmd_ack(cmd_ack), .tx_data(tx_data),
    .rsp_valid(rsp_valid), .rx_data(rx_data), .rsp_nack(rsp_nack), .rsp_arb(rsp_arb),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // Wired-AND bus with pull-ups
  assign scl_in = ~scl_oe & ~slv_scl_low;
  assign sda_in = ~sda_oe & ~slv_sda_low & ~force_sda_low;

  // Slave: bit index = SCL falls since accept, minus one when the command opens with START
  bit         cur_start, cur_read, slv_ack;
  logic [7:0] slv_byte;
  int         falls = 100;
  int         idx;
  logic       scl_prev = 1'b1;
  logic       obs [9];

  assign idx = falls - int'(cur_start);

  always_ff @(posedge clk) begin
    scl_prev <= scl_in;
    if (rsp_valid) falls <= 100;
    if (cmd_valid && cmd_ready) begin
      falls <= 0;
      for (int i = 0; i < 9; i++) obs[i] <= 1'bx;
    end else begin
      if (scl_prev && !scl_in) falls <= falls + 1;
      if (!scl_prev && scl_in && idx >= 0 && idx <= 8) obs[idx] <= sda_oe;
    end
  end

  always_comb begin
    slv_sda_low = 1'b0;
    if (idx == 8 && !cur_read && slv_ack) slv_sda_low = 1'b1;
    else if (idx >= 0 && idx < 8 && cur_read) slv_sda_low = ~slv_byte[3'(7 - idx)];
  end

  typedef struct {
    bit s, p, rd, ak;
    logic [7:0] tx;
    bit sa;
    logic [7:0] sb;
    int lat;
    bit nack;
    logic [7:0] rx;
  } vec_t;

  vec_t vecs [6];
  logic snap_scl, snap_sda;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: master's SDA enable for bit k (8 = ack bit)
  function automatic logic exp_sda(input bit rd, input bit ak, input logic [7:0] tx, input int k);
    if (k < 8) return rd ? 1'b0 : ~tx[3'(7 - k)];
    return rd ? ~ak : 1'b0;
  endfunction

  task automatic run_cmd(input bit s, input bit p, input bit rd, input bit ak,
                         input logic [7:0] tx, input bit sa, input logic [7:0] sb,
                         input int st_at, input int st_len, input int arb_at,
                         output int lat);
    @(negedge clk);
    cur_start = s; cur_read = rd; slv_ack = sa; slv_byte = sb;
    cmd_valid = 1'b1; cmd_start = s; cmd_stop = p; cmd_read = rd; cmd_ack = ak; tx_data = tx;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == st_at) slv_scl_low = 1'b1;
      if (lat == st_at + st_len) slv_scl_low = 1'b0;
      if (lat == arb_at) force_sda_low = 1'b1;
      if (lat == arb_at + 4) begin
        snap_scl = scl_oe;
        snap_sda = sda_oe;
      end
    end
    force_sda_low = 1'b0;
    slv_scl_low = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int st_at, input int st_len);
    int lat;
    run_cmd(v.s, v.p, v.rd, v.ak, v.tx, v.sa, v.sb, st_at, st_len, -10, lat);
    check_int("latency", lat, v.lat);
    check1("rsp_nack", rsp_nack, v.nack);
    check1("rsp_arb", rsp_arb, 1'b0);
    check8("rx_data", rx_data, v.rx);
    check1("busy_in_rsp", busy, 1'b1);
    check1("ready_in_rsp", cmd_ready, 1'b1);
    for (int k = 0; k < 9; k++)
      check1($sformatf("sda_oe_bit%0d", k), obs[k], exp_sda(v.rd, v.ak, v.tx, k));
    @(posedge clk); #1;
    check1("busy_after", busy, 1'b0);
    check1("rsp_valid_pulse", rsp_valid, 1'b0);
    check1("scl_oe_idle", scl_oe, !v.p);
    check1("sda_oe_idle", sda_oe, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    bit   prev_p;
    logic [7:0] model_rx;

    vecs[0] = '{1, 1, 0, 0, 8'hA5, 1, 8'h00, 177, 0, 8'h00};
    vecs[1] = '{1, 1, 1, 1, 8'h00, 0, 8'h3C, 177, 0, 8'h3C};
    vecs[2] = '{1, 1, 0, 0, 8'h10, 0, 8'h00, 177, 1, 8'h3C};
    vecs[3] = '{1, 0, 0, 0, 8'h5A, 1, 8'h00, 161, 0, 8'h3C};
    vecs[4] = '{0, 0, 0, 0, 8'h81, 1, 8'h00, 145, 0, 8'h3C};
    vecs[5] = '{0, 1, 1, 0, 8'h00, 0, 8'hC3, 161, 0, 8'hC3};

    arst_n = 1'b0;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_ack = 1'b0;
    tx_data = 8'h00;
    cur_start = 1'b0; cur_read = 1'b0; slv_ack = 1'b0; slv_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_scl_oe", scl_oe, 1'b0);
    check1("rst_sda_oe", sda_oe, 1'b0);
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check8("rst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_vec(vecs[i], -10, 0);

    // SCL held low by the slave for 20 clks from bit 3 Q2
    v = vecs[0];
    v.lat = 197;
    v.rx = 8'hC3;
    do_vec(v, 72, 20);

    // Arbitration loss on bit 0 of a 0xFF write
    run_cmd(1, 1, 0, 0, 8'hFF, 1, 8'h00, -10, 0, 28, lat);
    check_int("arb_latency", lat, 33);
    check1("arb_flag", rsp_arb, 1'b1);
    check1("arb_nack", rsp_nack, 1'b0);
    check1("arb_scl_released", snap_scl, 1'b0);
    check1("arb_sda_released", snap_sda, 1'b0);
    check8("arb_rx_kept", rx_data, 8'hC3);
    @(posedge clk); #1;
    check1("arb_ready", cmd_ready, 1'b1);
    check1("arb_scl_idle", scl_oe, 1'b0);
    check1("arb_sda_idle", sda_oe, 1'b0);

    prev_p = 1'b1;
    model_rx = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      v.s  = prev_p ? 1'b1 : 1'($urandom_range(0, 1));
      v.p  = 1'($urandom_range(0, 1));
      v.rd = 1'($urandom_range(0, 1));
      v.ak = 1'($urandom_range(0, 1));
      v.tx = 8'($urandom);
      v.sa = 1'($urandom_range(0, 1));
      v.sb = 8'($urandom);
      v.lat  = (int'(v.s) + 9 + int'(v.p)) * 4 * CLK_DIV + 1;
      v.nack = !v.rd && !v.sa;
      if (v.rd) model_rx = v.sb;
      v.rx = model_rx;
      do_vec(v, -10, 0);
      prev_p = v.p;
    end
    if (!prev_p) begin
      v = vecs[0];
      v.p = 1'b1;
      v.rx = model_rx;
      do_vec(v, -10, 0);
    end

    // Write without STOP, repeated-start read, reset asserted in bit 4
    v = '{1, 0, 0, 0, 8'h96, 1, 8'h00, 161, 0, model_rx};
    do_vec(v, -10, 0);
    @(negedge clk);
    cur_start = 1'b1; cur_read = 1'b1; slv_ack = 1'b0; slv_byte = 8'h5E;
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b1; cmd_ack = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (84) @(posedge clk);
    #2;
    check1("pre_reset_scl_low", scl_oe, 1'b1);
    check1("pre_reset_busy", busy, 1'b1);
    arst_n = 1'b0;
    #1;
    check1("async_rst_scl_oe", scl_oe, 1'b0);
    check1("async_rst_sda_oe", sda_oe, 1'b0);
    check1("async_rst_ready", cmd_ready, 1'b1);
    check1("async_rst_busy", busy, 1'b0);
    check8("async_rst_rx", rx_data, 8'h00);
    @(negedge clk);
    arst_n = 1'b1;

    v = vecs[0];
    v.rx = 8'h00;
    do_vec(v, -10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
